// File: rtl/el2_trace_capture.sv
// el2_trace_capture: buffers retire trace packets and serializes each one into a byte frame.
package el2_trace_pkg;
    typedef struct packed {
        logic        trace_rv_i_valid_ip;
        logic [31:0] trace_rv_i_insn_ip;
        logic [31:0] trace_rv_i_address_ip;
        logic        trace_rv_i_exception_ip;
        logic [4:0]  trace_rv_i_ecause_ip;
        logic        trace_rv_i_interrupt_ip;
        logic [31:0] trace_rv_i_tval_ip;
    } el2_trace_pkt_t;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] addr;
        logic        exc;
        logic [4:0]  ecause;
        logic        intr;
        logic [31:0] tval;
    } el2_trace_rec_t;
endpackage

module el2_trace_capture
    import el2_trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_l,
    input  logic           enable,
    input  el2_trace_pkt_t trace_pkt,
    input  logic           ovf_clr,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    output logic           tx_last,
    input  logic           tx_ready,
    output logic [7:0]     ovf_cnt,
    output logic           fifo_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {IDLE, HDR, ADDR, INSN, TVAL} state_t;

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]     ovf_cnt_q, ovf_cnt_d;
    el2_trace_rec_t mem [DEPTH];
    el2_trace_rec_t head, wr_rec;
    logic           full, hs, last_hs, push_req, push, drop, trap, more;
    logic [31:0]    word, shifted;

    assign head       = mem[rd_ptr_q[AW-1:0]];
    assign fifo_empty = wr_ptr_q == rd_ptr_q;
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign trap       = head.exc | head.intr;
    assign ovf_cnt    = ovf_cnt_q;
    assign wr_rec     = '{insn: trace_pkt.trace_rv_i_insn_ip, addr: trace_pkt.trace_rv_i_address_ip,
                          exc: trace_pkt.trace_rv_i_exception_ip, ecause: trace_pkt.trace_rv_i_ecause_ip,
                          intr: trace_pkt.trace_rv_i_interrupt_ip, tval: trace_pkt.trace_rv_i_tval_ip};

    // Frame byte selection from the FIFO head; everything is quiet in IDLE
    always_comb begin
        tx_valid = state_q != IDLE;
        tx_last  = (state_q == TVAL || (state_q == INSN && !trap)) && cnt_q == 2'd3;
        word     = state_q == ADDR ? head.addr : state_q == INSN ? head.insn : head.tval;
        shifted  = word >> {cnt_q, 3'b000};
        tx_data  = state_q == IDLE ? 8'h00 :
                   state_q == HDR  ? {1'b1, head.exc, head.intr, head.ecause} : shifted[7:0];
    end

    // FIFO pointers and overflow counter; a slot freed by the final handshake is reusable that cycle
    always_comb begin
        hs        = tx_valid & tx_ready;
        last_hs   = hs & tx_last;
        push_req  = enable & trace_pkt.trace_rv_i_valid_ip;
        push      = push_req & (~full | last_hs);
        drop      = push_req & ~push;
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = last_hs ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        more      = wr_ptr_d != rd_ptr_d;
        ovf_cnt_d = ovf_clr ? 8'h00 : (drop && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'h01 : ovf_cnt_q;
    end

    // Frame sequencer: header, 4 address bytes, 4 instruction bytes, optional 4 tval bytes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hs) cnt_d = state_q == HDR ? 2'd0 : cnt_q + 2'd1;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = HDR;
            HDR:     if (hs) state_d = ADDR;
            ADDR:    if (hs && cnt_q == 2'd3) state_d = INSN;
            INSN:    if (hs && cnt_q == 2'd3) state_d = trap ? TVAL : more ? HDR : IDLE;
            TVAL:    if (hs && cnt_q == 2'd3) state_d = more ? HDR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_cnt_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Packet storage, left unreset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= wr_rec;
    end
endmodule

// File: tb/tb_el2_trace_capture.sv
// tb_el2_trace_capture: directed vector and sequence checks of the trace frame serializer.
module tb_el2_trace_capture;
    import el2_trace_pkg::*;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic       en, vld, rdy;
        logic       tv;
        logic [7:0] td;
        logic       tl, fe;
    } vec_t;

    logic           clk = 1'b0, rst_l = 1'b0, enable = 1'b1, ovf_clr = 1'b0, tx_ready = 1'b0;
    el2_trace_pkt_t trace_pkt;
    logic [7:0]     tx_data, ovf_cnt;
    logic           tx_valid, tx_last, fifo_empty;
    int             total = 0, bad = 0;
    bq_t            got;
    vec_t           tbl[12];

    always #5 clk = ~clk;

    el2_trace_capture #(.DEPTH(4)) dut (
        .clk(clk), .rst_l(rst_l), .enable(enable), .trace_pkt(trace_pkt), .ovf_clr(ovf_clr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .ovf_cnt(ovf_cnt), .fifo_empty(fifo_empty)
    );

    function automatic el2_trace_pkt_t mk(logic exc, logic intr, logic [4:0] ec, logic [31:0] tv);
        el2_trace_pkt_t p;
        p.trace_rv_i_valid_ip     = 1'b1;
        p.trace_rv_i_insn_ip      = 32'h00A00093;
        p.trace_rv_i_address_ip   = 32'h80000010;
        p.trace_rv_i_exception_ip = exc;
        p.trace_rv_i_ecause_ip    = ec;
        p.trace_rv_i_interrupt_ip = intr;
        p.trace_rv_i_tval_ip      = tv;
        return p;
    endfunction

    function automatic vec_t v(logic en, logic vld, logic rdy, logic tv, logic [7:0] td, logic tl, logic fe);
        vec_t r;
        r.en = en; r.vld = vld; r.rdy = rdy; r.tv = tv; r.td = td; r.tl = tl; r.fe = fe;
        return r;
    endfunction

    function automatic bq_t frame(logic [7:0] h, logic [31:0] tv, bit trap);
        bq_t q = '{h, 8'h10, 8'h00, 8'h00, 8'h80, 8'h93, 8'h00, 8'hA0, 8'h00};
        if (trap) for (int i = 0; i < 4; i++) q.push_back(8'(tv >> (8 * i)));
        return q;
    endfunction

    function automatic logic [18:0] obs();
        return {tx_valid, tx_data, tx_last, fifo_empty, ovf_cnt};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_frame(input string nm, input bq_t e);
        bit ok;
        ok = got.size() == e.size();
        if (ok) foreach (e[i]) if (got[i] !== e[i]) ok = 0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d bytes (first %h) want %0d bytes (first %h)", nm, got.size(),
                     got.size() > 0 ? got[0] : 8'h00, e.size(), e[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input el2_trace_pkt_t p);
        trace_pkt = p;
        step();
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
    endtask

    // Gathers one frame from the handshakes, checking hold-under-stall and no mid-frame gaps
    task automatic collect(input bit tog);
        bit done = 0, stall = 0, ph = 1, started = 0;
        logic [7:0] pd = 8'h00;
        logic pl = 1'b0;
        int cyc = 0;
        got.delete();
        while (!done) begin
            if (started) chk("valid_hold", {31'd0, tx_valid}, 32'd1);
            if (stall) chk("stall_hold", {23'd0, tx_data, tx_last}, {23'd0, pd, pl});
            tx_ready = tog ? ph : 1'b1;
            ph = ~ph;
            stall = tx_valid && !tx_ready;
            pd = tx_data;
            pl = tx_last;
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                started = 1;
                done = tx_last;
            end
            step();
            cyc++;
            if (!done && cyc > 100) begin
                total++;
                bad++;
                $display("FAIL collect_timeout: got %0d bytes after %0d cycles, want frame end", got.size(), cyc);
                done = 1;
            end
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        int hi;
        bit found;
        tbl = '{v(0,1,1, 0,8'h00,0,1), v(1,1,1, 0,8'h00,0,0), v(1,0,1, 1,8'h80,0,0),
                v(1,0,1, 1,8'h10,0,0), v(1,0,1, 1,8'h00,0,0), v(1,0,1, 1,8'h00,0,0),
                v(1,0,1, 1,8'h80,0,0), v(1,0,1, 1,8'h93,0,0), v(1,0,1, 1,8'h00,0,0),
                v(1,0,1, 1,8'hA0,0,0), v(1,0,1, 1,8'h00,1,0), v(1,0,1, 0,8'h00,0,1)};
        trace_pkt = '0;
        #3;
        chk("reset_state", {13'd0, obs()}, {13'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00});
        #9 rst_l = 1'b1;
        step();

        foreach (tbl[i]) begin
            enable = tbl[i].en;
            trace_pkt = mk(0, 0, 0, 0);
            trace_pkt.trace_rv_i_valid_ip = tbl[i].vld;
            tx_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d", i), {13'd0, obs()},
                {13'd0, tbl[i].tv, tbl[i].td, tbl[i].tl, tbl[i].fe, 8'h00});
        end
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
        enable = 1'b1;
        tx_ready = 1'b0;

        push(mk(1, 0, 5'd2, 32'hDEADBEEF));
        collect(0);
        chk_frame("trap_frame", frame(8'hC2, 32'hDEADBEEF, 1));

        push(mk(0, 0, 0, 0));
        collect(1);
        chk_frame("backpressure_frame", frame(8'h80, 0, 0));
        chk("idle_after_frame", {30'd0, tx_valid, fifo_empty}, 32'd1);

        tx_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            trace_pkt = mk(0, 0, 5'(i), 0);
            step();
        end
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
        chk("ovf_after_6", {13'd0, obs()}, {13'd0, 1'b1, 8'h81, 1'b0, 1'b0, 8'd2});
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", {24'd0, ovf_cnt}, 32'd0);
        trace_pkt.trace_rv_i_valid_ip = 1'b1;
        repeat (300) step();
        chk("ovf_saturate", {24'd0, ovf_cnt}, 32'd255);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        trace_pkt.trace_rv_i_valid_ip = 1'b0;
        chk("ovf_clr_priority", {24'd0, ovf_cnt}, 32'd0);

        tx_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (tx_valid && tx_last) found = 1;
            else step();
        end
        chk("full_last_seen", {31'd0, found}, 32'd1);
        push(mk(1, 0, 5'd9, 32'h12345678));
        chk("full_push_accept", {15'd0, tx_valid, tx_data, fifo_empty, ovf_cnt},
            {15'd0, 1'b1, 8'h82, 1'b0, 8'h00});
        collect(0);
        chk_frame("drain_p2", frame(8'h82, 0, 0));
        chk("back_to_back", {31'd0, tx_valid}, 32'd1);
        tx_ready = 1'b1;
        collect(0);
        chk_frame("drain_p3", frame(8'h83, 0, 0));
        collect(0);
        chk_frame("drain_p4", frame(8'h84, 0, 0));
        collect(0);
        chk_frame("drain_p9", frame(8'hC9, 32'h12345678, 1));
        chk("drained", {30'd0, tx_valid, fifo_empty}, 32'd1);

        push(mk(0, 0, 0, 0));
        tx_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (tx_valid && tx_data == 8'h93) found = 1;
            else step();
        end
        chk("insn_reached", {31'd0, found}, 32'd1);
        tx_ready = 1'b0;
        #2 rst_l = 1'b0;
        #1 chk("midframe_reset", {13'd0, obs()}, {13'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00});
        step();
        #2 rst_l = 1'b1;
        tx_ready = 1'b1;
        hi = 0;
        repeat (20) begin
            step();
            if (tx_valid) hi++;
        end
        chk("quiet_after_reset", hi, 0);
        tx_ready = 1'b0;
        push(mk(1, 0, 5'd2, 32'hDEADBEEF));
        collect(0);
        chk_frame("frame_after_reset", frame(8'hC2, 32'hDEADBEEF, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/el2_trace_capture.md
EL2_TRACE_CAPTURE -- requirements
Module: el2_trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of trace packet FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1, the single clock for all state.
REQ-003 SHALL have port rst_l, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port enable, input, 1; when low, incoming packets are ignored.
REQ-005 SHALL have port trace_pkt, input, el2_trace_pkt_t, the per-cycle retire trace from the core.
REQ-006 SHALL have port ovf_clr, input, 1, a synchronous clear of ovf_cnt.
REQ-007 SHALL have port tx_data, output, 8, the serialized frame byte.
REQ-008 SHALL have port tx_valid, output, 1, which is high when tx_data holds a byte.
REQ-009 SHALL have port tx_last, output, 1, which marks the final byte of a frame and is valid only with tx_valid.
REQ-010 SHALL have port tx_ready, input, 1, the sink's acceptance; a byte transfers when tx_valid and tx_ready are both high.
REQ-011 SHALL have port ovf_cnt, output, 8, a saturating count of dropped packets.
REQ-012 SHALL have port fifo_empty, output, 1, which is high when the FIFO holds no packets.

Function
REQ-013 SHALL push trace_pkt into the FIFO on a cycle where enable=1, trace_rv_i_valid_ip=1 and the FIFO is not full.
REQ-014 SHALL drop the packet and increment ovf_cnt on a push attempt while the FIFO is full; ovf_cnt saturates at 255.
REQ-015 SHALL give ovf_clr priority over a same-cycle increment, so ovf_cnt becomes 0.
REQ-016 SHALL pop the FIFO head only on the tx_last handshake cycle.
REQ-017 SHALL count the FIFO as not full on a tx_last handshake cycle, so a same-cycle push is accepted.
REQ-018 SHALL wrap the FIFO read and write pointers modulo DEPTH and use an extra wrap bit to distinguish full from empty.
REQ-019 SHALL implement a frame FSM with states IDLE, HDR, ADDR, INSN and TVAL.
REQ-020 SHALL move IDLE->HDR on the cycle after the FIFO becomes non-empty, so tx_valid rises one cycle after the first push.
REQ-021 SHALL drive the HDR byte as {1'b1, exception, interrupt, ecause[4:0]}.
REQ-022 SHALL move HDR->ADDR->INSN, each on its byte handshake.
REQ-023 SHALL send ADDR and INSN as 4 bytes each, least-significant byte first, using a 2-bit byte counter reset at each state entry.
REQ-024 SHALL move INSN->TVAL after the 4th INSN byte when exception or interrupt is set; otherwise that byte carries tx_last.
REQ-025 SHALL send TVAL as 4 bytes, LSB first, with tx_last on the 4th byte.
REQ-026 SHALL produce frames of 9 bytes without a trap and 13 bytes with a trap.
REQ-027 SHALL move to HDR after tx_last when the FIFO is still non-empty after the pop, giving back-to-back frames with no idle cycle; otherwise it SHALL move to IDLE.
REQ-028 SHALL hold tx_data, tx_last and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-029 SHALL not deassert tx_valid mid-frame.
REQ-030 SHALL drive tx_valid low in IDLE.
REQ-031 SHALL let deassertion of enable mid-frame stop only new pushes; frames in flight and queued packets drain normally.
REQ-032 SHALL drive fifo_empty combinationally from the pointers.

Reset
REQ-033 SHALL, on rst_l low, immediately and asynchronously force the FSM to IDLE, the pointers to 0, ovf_cnt=0, tx_valid=0, tx_last=0, tx_data=0 and fifo_empty=1.
REQ-034 SHALL abandon any partial frame on reset mid-frame and start no frame until a new push occurs after reset release.
REQ-035 SHALL not reset the FIFO storage array; its contents are don't-care after reset.

Verification
REQ-036 SHALL cover a single push: valid packet, addr=0x80000010, insn=0x00A00093, no trap, tx_ready=1 -> 9 bytes 0x80,10,00,00,80,93,00,A0,00, with tx_last on byte 9.
REQ-037 SHALL cover a trap push: exception=1, ecause=2, tval=0xDEADBEEF -> header 0xC2 and 13 bytes ending EF,BE,AD,DE, with tx_last on DE.
REQ-038 SHALL cover overflow: tx_ready=0 and 6 valid pushes with DEPTH=4 -> ovf_cnt=2 and fifo_empty=0; then ovf_clr -> ovf_cnt=0.
REQ-039 SHALL cover backpressure: tx_ready toggling 1/0 every cycle -> tx_data stable during stalls and the frame byte sequence identical to REQ-036.
REQ-040 SHALL cover full boundary: full FIFO, push on the same cycle as the tx_last handshake -> packet accepted, ovf_cnt unchanged, next HDR on the following cycle.
REQ-041 SHALL cover mid-frame reset: assert rst_l low during the INSN state -> tx_valid=0 the same cycle, and no bytes output after release until a new push.
